// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 pixel store: the scanner reads the front buffer with a
// fixed one-cycle latency while the writer fills the back buffer.
module hub75_frame_buffer #(
    parameter int COLOR_BITS = 4,
    parameter int X_BITS     = 6,
    parameter int ROW_BITS   = 5
) (
    input  logic                    clk30,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic [X_BITS-1:0]       rd_x,
    input  logic [ROW_BITS-1:0]     rd_addr,
    output logic [3*COLOR_BITS-1:0] rd_rgb0,
    output logic [3*COLOR_BITS-1:0] rd_rgb1,
    output logic                    rd_valid,
    input  logic                    frame_start,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [X_BITS-1:0]       wr_x,
    input  logic [ROW_BITS:0]       wr_y,
    input  logic [3*COLOR_BITS-1:0] wr_rgb,
    input  logic                    wr_frame_done,
    output logic                    front_sel,
    output logic                    swap_pulse,
    output logic                    dbg_state_o
);

    localparam int PW    = 3 * COLOR_BITS;
    localparam int AW    = X_BITS + ROW_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_FILL = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   front_sel_q, front_sel_d;
    logic   swap_pulse_q, swap_pulse_d;
    logic   wr_ready_q;
    logic   rd_valid_q;
    logic   rd_sel_q;

    // Write handshake: a pixel transfers on a rising clk30 edge where
    // wr_valid && wr_ready are both high; wr_ready never depends on wr_valid.
    logic          wr_fire;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr_cat;

    assign wr_fire     = wr_valid && wr_ready_q && !reset;
    assign wr_bank     = {~front_sel_q, wr_y[ROW_BITS]};
    assign wr_addr     = {wr_y[ROW_BITS-1:0], wr_x};
    assign rd_addr_cat = {rd_addr, rd_x};

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_pulse_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (wr_frame_done) begin
                    if (frame_start) begin
                        front_sel_d  = ~front_sel_q;
                        swap_pulse_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (frame_start) begin
                    front_sel_d  = ~front_sel_q;
                    swap_pulse_d = 1'b1;
                    state_d      = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q      <= S_FILL;
            front_sel_q  <= 1'b0;
            swap_pulse_q <= 1'b0;
            wr_ready_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            swap_pulse_q <= swap_pulse_d;
            wr_ready_q   <= (state_d == S_FILL);
            rd_valid_q   <= rd_en;
            if (rd_en) begin
                rd_sel_q <= front_sel_q;
            end
        end
    end

    // Bank index is {buffer, half}; each bank is a simple dual-port RAM whose
    // output register holds its value between reads and clears on reset.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [PW-1:0] mem [DEPTH];
        logic [PW-1:0] rd_q;

        always_ff @(posedge clk30) begin
            if (wr_fire && (wr_bank == 2'(b))) begin
                mem[wr_addr] <= wr_rgb;
            end
        end

        always_ff @(posedge clk30) begin
            if (reset) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr_cat];
            end
        end
    end

    assign rd_rgb0     = rd_sel_q ? g_bank[2].rd_q : g_bank[0].rd_q;
    assign rd_rgb1     = rd_sel_q ? g_bank[3].rd_q : g_bank[1].rd_q;
    assign rd_valid    = rd_valid_q;
    assign wr_ready    = wr_ready_q;
    assign front_sel   = front_sel_q;
    assign swap_pulse  = swap_pulse_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed bench for hub75_frame_buffer: reads are scored against an expected
// queue filled when each read is issued.
module tb_hub75_frame_buffer;

    localparam int CB = 4;
    localparam int XB = 6;
    localparam int RB = 5;
    localparam int PW = 3 * CB;

    logic          clk30 = 1'b0;
    logic          reset;
    logic          rd_en;
    logic [XB-1:0] rd_x;
    logic [RB-1:0] rd_addr;
    logic [PW-1:0] rd_rgb0;
    logic [PW-1:0] rd_rgb1;
    logic          rd_valid;
    logic          frame_start;
    logic          wr_valid;
    logic          wr_ready;
    logic [XB-1:0] wr_x;
    logic [RB:0]   wr_y;
    logic [PW-1:0] wr_rgb;
    logic          wr_frame_done;
    logic          front_sel;
    logic          swap_pulse;
    logic          dbg_state_o;

    logic [2*PW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    hub75_frame_buffer #(.COLOR_BITS(CB), .X_BITS(XB), .ROW_BITS(RB)) dut (
        .clk30        (clk30),
        .reset        (reset),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_addr      (rd_addr),
        .rd_rgb0      (rd_rgb0),
        .rd_rgb1      (rd_rgb1),
        .rd_valid     (rd_valid),
        .frame_start  (frame_start),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_rgb       (wr_rgb),
        .wr_frame_done(wr_frame_done),
        .front_sel    (front_sel),
        .swap_pulse   (swap_pulse),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock and reset
    always #5 clk30 = ~clk30;

    // Advance one edge; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk30);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_write(input logic [XB-1:0] x, input logic [RB:0] y, input logic [PW-1:0] rgb);
        check("wr_ready_before_write", 24'(wr_ready), 24'(1));
        wr_valid = 1'b1;
        wr_x     = x;
        wr_y     = y;
        wr_rgb   = rgb;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [XB-1:0] x, input logic [RB-1:0] a,
                           input logic [PW-1:0] e0, input logic [PW-1:0] e1);
        logic [2*PW-1:0] exp;
        rd_en   = 1'b1;
        rd_x    = x;
        rd_addr = a;
        exp_q.push_back({e1, e0});
        step();
        rd_en = 1'b0;
        check("rd_valid", 24'(rd_valid), 24'(1));
        if (rd_valid === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rd_data", {rd_rgb1, rd_rgb0}, exp);
        end else begin
            checks++;
            errors++;
            $error("FAIL rd_data: observed no valid read, expected %0h", {e1, e0});
        end
    endtask

    initial begin
        reset         = 1'b1;
        rd_en         = 1'b0;
        rd_x          = '0;
        rd_addr       = '0;
        frame_start   = 1'b0;
        wr_valid      = 1'b0;
        wr_x          = '0;
        wr_y          = '0;
        wr_rgb        = '0;
        wr_frame_done = 1'b0;

        // Reset held three cycles
        step();
        step();
        step();
        check("rst_rd_valid", 24'(rd_valid), 24'(0));
        check("rst_rd_rgb0", 24'(rd_rgb0), 24'(0));
        check("rst_rd_rgb1", 24'(rd_rgb1), 24'(0));
        check("rst_front_sel", 24'(front_sel), 24'(0));
        check("rst_wr_ready", 24'(wr_ready), 24'(0));
        check("rst_swap_pulse", 24'(swap_pulse), 24'(0));
        check("rst_state", 24'(dbg_state_o), 24'(0));
        reset = 1'b0;
        step();
        check("post_rst_wr_ready", 24'(wr_ready), 24'(1));

        // Fill buffer 1 while buffer 0 is displayed
        do_write(6'd5, 7'(3), 12'hABC);
        do_write(6'd5, 7'(35), 12'h123);
        do_write(6'd0, 7'(0), 12'h456);
        do_write(6'd0, 7'(32), 12'h5A5);
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        check("done_wr_ready", 24'(wr_ready), 24'(0));
        check("done_state_wait", 24'(dbg_state_o), 24'(1));
        check("done_no_swap_yet", 24'(front_sel), 24'(0));

        // Frame boundary swaps buffer 1 to the front
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("swap1_pulse", 24'(swap_pulse), 24'(1));
        check("swap1_front_sel", 24'(front_sel), 24'(1));
        check("swap1_wr_ready", 24'(wr_ready), 24'(1));
        step();
        check("swap1_pulse_clear", 24'(swap_pulse), 24'(0));
        do_read(6'd5, 5'd3, 12'hABC, 12'h123);

        // Idle cycle: rd_valid drops, data holds
        step();
        check("hold_rd_valid", 24'(rd_valid), 24'(0));
        check("hold_rd_rgb0", 24'(rd_rgb0), 24'(12'hABC));

        // Writes land in buffer 0 and leave the front untouched
        do_write(6'd5, 7'(3), 12'hFFF);
        do_write(6'd5, 7'(35), 12'h9A5);
        do_read(6'd5, 5'd3, 12'hABC, 12'h123);

        // Done and frame_start together swap immediately, staying in fill
        wr_frame_done = 1'b1;
        frame_start   = 1'b1;
        step();
        wr_frame_done = 1'b0;
        frame_start   = 1'b0;
        check("simul_pulse", 24'(swap_pulse), 24'(1));
        check("simul_front_sel", 24'(front_sel), 24'(0));
        check("simul_wr_ready", 24'(wr_ready), 24'(1));
        check("simul_state_fill", 24'(dbg_state_o), 24'(0));
        do_read(6'd5, 5'd3, 12'hFFF, 12'h9A5);

        // frame_start alone in fill does not swap
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs_alone_pulse", 24'(swap_pulse), 24'(0));
        check("fs_alone_front_sel", 24'(front_sel), 24'(0));

        // Back-pressure: writes blocked while waiting for the frame boundary
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        wr_valid = 1'b1;
        wr_x     = 6'd0;
        wr_y     = 7'd0;
        wr_rgb   = 12'h777;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0 || i == 9) check("bp_wr_ready", 24'(wr_ready), 24'(0));
        end
        // A second done while waiting is ignored
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        wr_valid = 1'b0;
        check("bp_still_wait", 24'(dbg_state_o), 24'(1));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("bp_swap_pulse", 24'(swap_pulse), 24'(1));
        check("bp_front_sel", 24'(front_sel), 24'(1));
        do_read(6'd0, 5'd0, 12'h456, 12'h5A5);
        checks++;
        assert (rd_rgb0 !== 12'h777) else begin
            errors++;
            $error("FAIL bp_blocked: observed %0h expected not 777", rd_rgb0);
        end

        // Reset while a swap is pending
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        check("mid_wait_state", 24'(dbg_state_o), 24'(1));
        check("mid_wait_front_sel", 24'(front_sel), 24'(1));
        reset   = 1'b1;
        rd_en   = 1'b1;
        rd_x    = 6'd5;
        rd_addr = 5'd3;
        step();
        rd_en = 1'b0;
        check("mid_rst_front_sel", 24'(front_sel), 24'(0));
        check("mid_rst_wr_ready", 24'(wr_ready), 24'(0));
        check("mid_rst_rd_valid", 24'(rd_valid), 24'(0));
        check("mid_rst_rd_rgb0", 24'(rd_rgb0), 24'(0));
        reset       = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("post_rst_fs_pulse", 24'(swap_pulse), 24'(0));
        check("post_rst_fs_front_sel", 24'(front_sel), 24'(0));
        check("post_rst_wr_ready1", 24'(wr_ready), 24'(1));
        step();
        check("post_rst_pulse_idle", 24'(swap_pulse), 24'(0));

        check("exp_q_empty", 24'(exp_q.size()), 24'(0));

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
